// File: rtl/signal_gen_pkg.sv
// Shared types and defaults for the signal-generator playback path.
package signal_gen_pkg;

   localparam int unsigned DAC_WIDTH_DEF  = 14;
   localparam int unsigned ADDR_WIDTH_DEF = 12;
   localparam int unsigned MEM_WIDTH_DEF  = 16;
   localparam int unsigned RATE_WIDTH     = 32;
   localparam int unsigned BRAM_LATENCY   = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // A decimation rate of zero behaves like one
   function automatic logic [RATE_WIDTH-1:0] rate_clamp(input logic [RATE_WIDTH-1:0] rate);
      return (rate == '0) ? RATE_WIDTH'(1) : rate;
   endfunction

endpackage

// File: rtl/dac_dec_counter.sv
// Decimation counter: counts 0..max(rate,1)-1 and raises tick_o on the last count.
// The period length is latched at each wrap, so a rate change applies to the
// following period and the count is only ever compared against its own period.
module dac_dec_counter
   import signal_gen_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear_i,
   input  logic [RATE_WIDTH-1:0] rate_i,
   output logic                  tick_o
);

   logic [RATE_WIDTH-1:0] cnt_q, cnt_d;
   logic [RATE_WIDTH-1:0] lim_q, lim_d;
   logic                  tick_q, tick_d;

   // Next count, period reload on clear or wrap, and look-ahead tick
   always_comb begin
      cnt_d = cnt_q + RATE_WIDTH'(1);
      lim_d = lim_q;
      if (clear_i || tick_q) begin
         cnt_d = '0;
         lim_d = rate_clamp(rate_i);
      end
      tick_d = (cnt_d == (lim_d - RATE_WIDTH'(1)));
   end

   // Counter state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         lim_q  <= RATE_WIDTH'(1);
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         lim_q  <= lim_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/dac_sample_player.sv
// Waveform playback from a 1-cycle-latency BRAM to the DAC sample bus.
// A read issued while bram_en is high returns data in the following cycle,
// which is captured into dac_data (with a dac_valid strobe) at the next edge.
// Optional build macro DAC_OFFSET_BINARY_EN: invert the DAC MSB (offset binary).
module dac_sample_player
   import signal_gen_pkg::*;
#(
   parameter int unsigned DAC_WIDTH  = DAC_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned MEM_WIDTH  = MEM_WIDTH_DEF
) (
   input  logic                  axi_clock,
   input  logic                  rst,
   input  logic                  en_read,
   input  logic                  rst_read,
   input  logic                  continous,
   input  logic [RATE_WIDTH-1:0] dec_rate,
   input  logic [31:0]           dac_default,
   input  logic [ADDR_WIDTH-1:0] last_addr,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic                  bram_en,
   input  logic [MEM_WIDTH-1:0]  bram_dout,
   output logic [DAC_WIDTH-1:0]  dac_data,
   output logic                  dac_valid,
   output logic                  busy,
   output logic                  done
);

`ifdef DAC_OFFSET_BINARY_EN
   localparam logic [DAC_WIDTH-1:0] DAC_MSB_MASK = {1'b1, {(DAC_WIDTH-1){1'b0}}};

   function automatic logic [DAC_WIDTH-1:0] to_dac(input logic [DAC_WIDTH-1:0] s);
      return s ^ DAC_MSB_MASK;
   endfunction
`else
   function automatic logic [DAC_WIDTH-1:0] to_dac(input logic [DAC_WIDTH-1:0] s);
      return s;
   endfunction
`endif

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  bram_en_q, bram_en_d;
   logic                  rd_vld_q, rd_vld_d;
   logic [1:0]            fin_q, fin_d;
   logic                  stop_q, stop_d;
   logic [DAC_WIDTH-1:0]  dac_data_q, dac_data_d;
   logic                  dac_valid_q, dac_valid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  tick;
   logic                  clear_c;
   logic                  unused_bits;

   assign unused_bits = ^{dac_default[31:DAC_WIDTH], bram_dout[MEM_WIDTH-1:DAC_WIDTH]};

   // Counter only runs while playing (PRIME/RUN) in both current and next cycle
   assign clear_c = rst_read
                  || !((state_q == ST_PRIME) || (state_q == ST_RUN))
                  || !((state_d == ST_PRIME) || (state_d == ST_RUN));

   dac_dec_counter u_dec_counter (
      .clk     (axi_clock),
      .rst     (rst),
      .clear_i (clear_c),
      .rate_i  (dec_rate),
      .tick_o  (tick)
   );

   // Next state, read issue, end-of-waveform tracking and DAC output selection
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      bram_en_d   = 1'b0;
      rd_vld_d    = bram_en_q;
      fin_d       = {fin_q[0], 1'b0};
      stop_d      = stop_q;
      dac_data_d  = dac_data_q;
      dac_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (en_read) begin
               state_d   = ST_PRIME;
               addr_d    = '0;
               bram_en_d = 1'b1;
            end
         end
         ST_PRIME, ST_RUN: begin
            if (!en_read) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
               if (tick && !stop_q) begin
                  if (addr_q == last_addr) begin
                     if (continous) begin
                        addr_d    = '0;
                        bram_en_d = 1'b1;
                     end else begin
                        // last sample still has its own period plus pipeline to play out
                        stop_d   = 1'b1;
                        fin_d[0] = 1'b1;
                     end
                  end else begin
                     addr_d    = addr_q + ADDR_WIDTH'(1);
                     bram_en_d = 1'b1;
                  end
               end
               if (fin_q[1]) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (!en_read) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (rst_read) begin
         state_d   = ST_IDLE;
         addr_d    = '0;
         bram_en_d = 1'b0;
      end

      if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
         fin_d      = 2'b00;
         stop_d     = 1'b0;
         dac_data_d = to_dac(dac_default[DAC_WIDTH-1:0]);
      end else if ((state_q == ST_RUN) && rd_vld_q) begin
         dac_data_d  = to_dac(bram_dout[DAC_WIDTH-1:0]);
         dac_valid_d = 1'b1;
      end

      busy_d = (state_d == ST_PRIME) || (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State and registered outputs
   always_ff @(posedge axi_clock or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         bram_en_q   <= 1'b0;
         rd_vld_q    <= 1'b0;
         fin_q       <= 2'b00;
         stop_q      <= 1'b0;
         dac_data_q  <= '0;
         dac_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         bram_en_q   <= bram_en_d;
         rd_vld_q    <= rd_vld_d;
         fin_q       <= fin_d;
         stop_q      <= stop_d;
         dac_data_q  <= dac_data_d;
         dac_valid_q <= dac_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bram_addr = addr_q;
   assign bram_en   = bram_en_q;
   assign dac_data  = dac_data_q;
   assign dac_valid = dac_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_dac_sample_player.sv
// Self-checking bench for dac_sample_player: directed table, corner sequences,
// and randomized playback runs checked against a closed-form timing model.
module tb_dac_sample_player;

   logic        clk;
   logic        rst;
   logic        en_read;
   logic        rst_read;
   logic        continous;
   logic [31:0] dec_rate;
   logic [31:0] dac_default;
   logic [11:0] last_addr;
   logic [11:0] bram_addr;
   logic        bram_en;
   logic [15:0] bram_dout;
   logic [13:0] dac_data;
   logic        dac_valid;
   logic        busy;
   logic        done;

   logic [15:0] mem [0:4095];

   int checks;
   int failures;

   dac_sample_player dut (
      .axi_clock   (clk),
      .rst         (rst),
      .en_read     (en_read),
      .rst_read    (rst_read),
      .continous   (continous),
      .dec_rate    (dec_rate),
      .dac_default (dac_default),
      .last_addr   (last_addr),
      .bram_addr   (bram_addr),
      .bram_en     (bram_en),
      .bram_dout   (bram_dout),
      .dac_data    (dac_data),
      .dac_valid   (dac_valid),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 1-cycle-latency waveform BRAM
   always @(posedge clk) begin
      if (bram_en) bram_dout <= mem[bram_addr];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] dec;
      logic [11:0] last;
      logic        cont;
      int          t;
      logic        valid;
      logic [13:0] data;
      logic        busy;
      logic        done;
   } vec_t;

   vec_t vecs[$];

   localparam logic [31:0] DEF = 32'hABCD_1555;

   function automatic logic [13:0] fmt(input logic [13:0] v);
`ifdef DAC_OFFSET_BINARY_EN
      return v ^ 14'h2000;
`else
      return v;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add_vec(input logic [31:0] dec, input logic [11:0] last, input logic cont,
                          input int t, input logic valid, input logic [13:0] data,
                          input logic b, input logic d);
      vec_t v;
      v.dec = dec; v.last = last; v.cont = cont; v.t = t;
      v.valid = valid; v.data = data; v.busy = b; v.done = d;
      vecs.push_back(v);
   endtask

   // Clear to IDLE, load parameters, then start; returns at t=0 (PRIME cycle)
   task automatic start_play(input logic [31:0] dec, input logic [11:0] last,
                             input logic cont, input logic [31:0] def);
      en_read  = 1'b0;
      rst_read = 1'b1;
      step();
      rst_read    = 1'b0;
      dec_rate    = dec;
      last_addr   = last;
      continous   = cont;
      dac_default = def;
      step();
      en_read = 1'b1;
      step();
   endtask

   task automatic check_idle(input string tag, input logic [31:0] def);
      check({tag, " busy"},  32'(busy),      32'd0);
      check({tag, " done"},  32'(done),      32'd0);
      check({tag, " valid"}, 32'(dac_valid), 32'd0);
      check({tag, " en"},    32'(bram_en),   32'd0);
      check({tag, " data"},  32'(dac_data),  32'(fmt(def[13:0])));
   endtask

   // Random playback run checked every cycle against closed-form expectations
   task automatic run_random(input int idx);
      logic [31:0] dec, def;
      logic [11:0] last;
      logic        cont;
      int n, l, m, done_t;
      dec    = 32'($urandom_range(0, 5));
      n      = (dec == 0) ? 1 : int'(dec);
      l      = $urandom_range(0, 7);
      last   = 12'(l);
      cont   = 1'($urandom_range(0, 1));
      def    = $urandom;
      done_t = 2 + (l + 1) * n;
      m      = $urandom_range(1, done_t + 4);

      en_read = 1'b0; dec_rate = dec; last_addr = last; continous = cont; dac_default = def;
      step();
      check_idle($sformatf("rnd%0d pre", idx), def);
      en_read = 1'b1;
      step();
      for (int t = 0; t < m; t++) begin
         logic        e_busy, e_done, e_valid, e_en;
         logic [11:0] e_addr;
         logic [13:0] e_data;
         e_busy = 1'b1; e_done = 1'b0; e_valid = 1'b0; e_en = 1'b0;
         e_addr = '0; e_data = def[13:0];
         if (!cont && t >= done_t) begin
            e_busy = 1'b0; e_done = 1'b1;
         end else begin
            if ((t % n == 0) && (cont || (t / n) <= l)) begin
               e_en   = 1'b1;
               e_addr = 12'((t / n) % (l + 1));
            end
            if (t >= 2) begin
               e_valid = ((t - 2) % n == 0);
               e_data  = mem[((t - 2) / n) % (l + 1)][13:0];
            end
         end
         check($sformatf("rnd%0d t%0d busy", idx, t),  32'(busy),      32'(e_busy));
         check($sformatf("rnd%0d t%0d done", idx, t),  32'(done),      32'(e_done));
         check($sformatf("rnd%0d t%0d valid", idx, t), 32'(dac_valid), 32'(e_valid));
         check($sformatf("rnd%0d t%0d en", idx, t),    32'(bram_en),   32'(e_en));
         if (e_en) check($sformatf("rnd%0d t%0d addr", idx, t), 32'(bram_addr), 32'(e_addr));
         check($sformatf("rnd%0d t%0d data", idx, t),  32'(dac_data),  32'(fmt(e_data)));
         if (t != m - 1) step();
      end
      en_read = 1'b0;
      step();
      check_idle($sformatf("rnd%0d stop", idx), def);
   endtask

   initial begin
      logic found;
      checks = 0; failures = 0;
      rst = 1'b1; en_read = 1'b0; rst_read = 1'b0; continous = 1'b0;
      dec_rate = 32'd1; dac_default = DEF; last_addr = 12'd0;
      for (int i = 0; i < 4096; i++) mem[i] = 16'(i + 1);

      // Reset values, dac_data stays 0 until the first clock after release
      #2;
      check("rst addr",  32'(bram_addr), 32'd0);
      check("rst en",    32'(bram_en),   32'd0);
      check("rst valid", 32'(dac_valid), 32'd0);
      check("rst busy",  32'(busy),      32'd0);
      check("rst done",  32'(done),      32'd0);
      check("rst data",  32'(dac_data),  32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      check("rst data held", 32'(dac_data), 32'd0);
      step();
      check_idle("idle after rst", DEF);

      // Directed table, BRAM[i] = i+1
      add_vec(1, 3, 0, 0, 0, DEF[13:0], 1, 0);
      add_vec(1, 3, 0, 2, 1, 14'd1, 1, 0);
      add_vec(1, 3, 0, 3, 1, 14'd2, 1, 0);
      add_vec(1, 3, 0, 4, 1, 14'd3, 1, 0);
      add_vec(1, 3, 0, 5, 1, 14'd4, 1, 0);
      add_vec(1, 3, 0, 6, 0, DEF[13:0], 0, 1);
      add_vec(1, 3, 0, 9, 0, DEF[13:0], 0, 1);
      add_vec(0, 3, 0, 2, 1, 14'd1, 1, 0);
      add_vec(0, 3, 0, 5, 1, 14'd4, 1, 0);
      add_vec(0, 3, 0, 6, 0, DEF[13:0], 0, 1);
      add_vec(4, 2, 1, 2, 1, 14'd1, 1, 0);
      add_vec(4, 2, 1, 3, 0, 14'd1, 1, 0);
      add_vec(4, 2, 1, 6, 1, 14'd2, 1, 0);
      add_vec(4, 2, 1, 10, 1, 14'd3, 1, 0);
      add_vec(4, 2, 1, 14, 1, 14'd1, 1, 0);
      add_vec(4, 2, 1, 15, 0, 14'd1, 1, 0);
      add_vec(4, 2, 1, 18, 1, 14'd2, 1, 0);
      add_vec(1, 0, 1, 2, 1, 14'd1, 1, 0);
      add_vec(1, 0, 1, 7, 1, 14'd1, 1, 0);
      add_vec(1, 0, 0, 2, 1, 14'd1, 1, 0);
      add_vec(1, 0, 0, 3, 0, DEF[13:0], 0, 1);
      add_vec(3, 1, 0, 2, 1, 14'd1, 1, 0);
      add_vec(3, 1, 0, 4, 0, 14'd1, 1, 0);
      add_vec(3, 1, 0, 5, 1, 14'd2, 1, 0);
      add_vec(3, 1, 0, 7, 0, 14'd2, 1, 0);
      add_vec(3, 1, 0, 8, 0, DEF[13:0], 0, 1);

      foreach (vecs[i]) begin
         start_play(vecs[i].dec, vecs[i].last, vecs[i].cont, DEF);
         repeat (vecs[i].t) step();
         check($sformatf("vec%0d valid", i), 32'(dac_valid), 32'(vecs[i].valid));
         check($sformatf("vec%0d data", i),  32'(dac_data),  32'(fmt(vecs[i].data)));
         check($sformatf("vec%0d busy", i),  32'(busy),      32'(vecs[i].busy));
         check($sformatf("vec%0d done", i),  32'(done),      32'(vecs[i].done));
      end

      // rst_read mid-RUN at address 5, then restart from sample 0
      start_play(2, 10, 0, DEF);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (bram_en && bram_addr == 12'd5) found = 1'b1;
         else step();
      end
      check("rst_read reach addr5", 32'(found), 32'd1);
      rst_read = 1'b1;
      step();
      rst_read = 1'b0;
      check("rst_read addr", 32'(bram_addr), 32'd0);
      check_idle("rst_read", DEF);
      step();
      check("restart en",   32'(bram_en),   32'd1);
      check("restart addr", 32'(bram_addr), 32'd0);
      check("restart busy", 32'(busy),      32'd1);
      step(); step();
      check("restart valid", 32'(dac_valid), 32'd1);
      check("restart data",  32'(dac_data),  32'(fmt(14'd1)));

      // en_read falling mid-RUN: idle next cycle, address kept, restart at 0
      start_play(2, 10, 0, DEF);
      repeat (5) step();
      en_read = 1'b0;
      step();
      check_idle("stop", DEF);
      check("stop addr kept", 32'(bram_addr), 32'd2);
      en_read = 1'b1;
      step();
      check("resume en",   32'(bram_en),   32'd1);
      check("resume addr", 32'(bram_addr), 32'd0);

      // dec_rate change mid-run applies from the next wrap (5 -> 2)
      start_play(5, 100, 1, DEF);
      repeat (5) step();
      check("rate chg en t5", 32'(bram_en), 32'd1);
      dec_rate = 32'd2;
      for (int t = 6; t <= 14; t++) begin
         step();
         check($sformatf("rate chg en t%0d", t), 32'(bram_en),
               32'((t == 10) || (t == 12) || (t == 14)));
      end

      // Async reset between edges during RUN
      start_play(2, 10, 1, DEF);
      repeat (7) step();
      #2 rst = 1'b1;
      #1;
      check("async busy",  32'(busy),      32'd0);
      check("async done",  32'(done),      32'd0);
      check("async valid", 32'(dac_valid), 32'd0);
      check("async en",    32'(bram_en),   32'd0);
      check("async addr",  32'(bram_addr), 32'd0);
      check("async data",  32'(dac_data),  32'd0);
      #1 rst = 1'b0;
      en_read = 1'b0;
      step();
      check_idle("after async", DEF);

      // Sample/default formatting with zero sample and all-ones default
      mem[0] = 16'hC000;
      start_play(1, 0, 1, 32'hFFFF_FFFF);
`ifdef DAC_OFFSET_BINARY_EN
      check("fmt default", 32'(dac_data), 32'h1FFF);
`else
      check("fmt default", 32'(dac_data), 32'h3FFF);
`endif
      step(); step();
`ifdef DAC_OFFSET_BINARY_EN
      check("fmt sample", 32'(dac_data), 32'h2000);
`else
      check("fmt sample", 32'(dac_data), 32'h0000);
`endif

      // Randomized runs
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      en_read = 1'b0; rst_read = 1'b1;
      step();
      rst_read = 1'b0;
      for (int r = 0; r < 25; r++) run_random(r);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
